axil_bram_ctrl: RTL and testbench
=================================

AXIL_BRAM_CTRL -- requirements
Module: axil_bram_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, AXI4-Lite address width (minimum 10).
REQ-002 SHALL have port: clk  in  1  single clock; all logic on posedge except the memory port, which is sampled by the memory on negedge.
REQ-003 SHALL have port: rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports: s_axi_awaddr in ADDR_W, s_axi_awvalid in 1, s_axi_awready out 1  (write-address channel).
REQ-005 SHALL have ports: s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1  (write-data channel).
REQ-006 SHALL have ports: s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1  (write-response channel).
REQ-007 SHALL have ports: s_axi_araddr in ADDR_W, s_axi_arvalid in 1, s_axi_arready out 1  (read-address channel).
REQ-008 SHALL have ports: s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1  (read-data channel).
REQ-009 SHALL have ports: mem_we out 1, mem_addr out 8, mem_din out 8, mem_dout in 8  (initiator side of the 256x8 memory: write-enable, address, write data, read data).

Function
REQ-010 SHALL map word address addr[9:2] to mem_addr; addr[1:0] ignored; one memory byte per 32-bit word.
REQ-011 SHALL run FSM states IDLE, WRITE, WRESP, READ, RDATA; only one transaction in flight.
REQ-012 In IDLE, awready and wready SHALL be asserted independently until each channel's handshake completes; AW and W accepted in either order or the same cycle, and each is latched.
REQ-013 When both AW and W are latched, FSM SHALL enter WRITE for exactly one cycle: mem_we=1 if wstrb[0]=1, else 0; mem_din=wdata[7:0].
REQ-014 WRITE SHALL go to WRESP, with bvalid=1 and bresp=OKAY (2'b00); bvalid held until bready, then go to IDLE.
REQ-015 In IDLE with no AW/W partially latched, arready SHALL be 1; on AR handshake at cycle N, mem_addr SHALL be driven in cycle N+1 (READ, mem_we=0).
REQ-016 In READ, mem_dout SHALL be captured at the end of the cycle; rvalid=1 from cycle N+2 (RDATA), rdata={24'h0, captured byte}, rresp=OKAY; rdata stable until rready.
REQ-017 If arvalid and a write handshake (AW or W) occur in the same IDLE cycle, the write SHALL win; arready SHALL be 0 that cycle; AR is accepted after the write completes.
REQ-018 Once AW or W alone is latched, arready SHALL stay 0 until the write response handshakes.
REQ-019 mem_we SHALL be 1 only in WRITE; mem_addr/mem_din SHALL hold their last values otherwise.
REQ-020 Back-to-back: bvalid&bready or rvalid&rready in cycle M SHALL allow a new handshake in cycle M+1.

Reset
REQ-021 On rst_n=0, all outputs SHALL clear asynchronously: awready, wready, arready, bvalid, rvalid, mem_we = 0; bresp, rresp, rdata, mem_addr, mem_din = 0; FSM=IDLE; latch flags cleared.
REQ-022 A transaction in progress when reset asserts SHALL be discarded; no mem_we pulse SHALL occur during or on release of reset.
REQ-023 Ready outputs SHALL rise no earlier than the first posedge after rst_n deasserts.

Configuration
REQ-024 Macro AXIL_BRAM_SLVERR_EN defined: addr[ADDR_W-1:10] != 0 SHALL yield SLVERR (2'b10) on bresp/rresp, with no mem_we pulse for writes and rdata=0 for reads; latency unchanged.
REQ-025 Macro undefined: upper address bits SHALL be ignored (aliasing), and the response SHALL always be OKAY.

Verification
REQ-026 Reset then read addr 0x0000_0008 (memory holds 0xB2 at index 2) -> rvalid two cycles after AR handshake, rdata=0x0000_00B2, rresp=0.
REQ-027 W (0xA5, wstrb=1) two cycles before AW=0x0000_0040 -> single mem_we pulse, mem_addr=0x10, mem_din=0xA5, bresp=0; read 0x40 returns 0x0000_00A5.
REQ-028 wstrb=0 write of 0x55 to 0x0000_0004 -> no mem_we, bresp=0; read returns the prior value.
REQ-029 arvalid, awvalid, and wvalid in the same cycle -> write completes first; read then returns the newly written byte; bready held low 3 cycles keeps bvalid/bresp stable.
REQ-030 With AXIL_BRAM_SLVERR_EN, write to 0x0000_0400 -> bresp=2'b10, no mem_we; read 0x0000_0400 -> rresp=2'b10, rdata=0; without the macro, same write lands at mem_addr 0x00 with OKAY.
REQ-031 Assert rst_n low during WRITE and during RDATA -> mem_we=0 immediately, bvalid/rvalid=0; after release, next read of the target address returns the unchanged value.

Source files
------------

// File: rtl/axil_bram_ctrl.sv
// AXI4-Lite slave in front of a 256x8 memory that samples its port on negedge; one byte per 32-bit word.
// Optional feature: define AXIL_BRAM_SLVERR_EN to answer SLVERR for any address at or above 0x400.
module axil_bram_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              mem_we,
  output logic [7:0]        mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic [2:0]        dbg_state
);

  // Handshakes: a beat transfers on a posedge where valid and ready are both high;
  // valid/payload stay put until that edge, ready may depend on valid combinationally.
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;

  state_t     state, state_d;
  logic       rdy_en;
  logic       aw_q, w_q;
  logic [7:0] awidx_q, wbyte_q;
  logic       awerr_q, wen_q, rd_err_q;
  logic       aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic       aw_err, ar_err;
  logic       unused_bits;

`ifdef AXIL_BRAM_SLVERR_EN
  assign aw_err = (s_axi_awaddr >> 10) != '0;
  assign ar_err = (s_axi_araddr >> 10) != '0;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata[31:8], s_axi_wstrb[3:1]};

  // rdy_en keeps every ready low until the first posedge after reset release.
  assign s_axi_awready = rdy_en && (state == IDLE) && !aw_q;
  assign s_axi_wready  = rdy_en && (state == IDLE) && !w_q;
  assign s_axi_arready = rdy_en && (state == IDLE) && !aw_q && !w_q
                         && !s_axi_awvalid && !s_axi_wvalid;
  assign s_axi_bvalid  = (state == WRESP);
  assign s_axi_rvalid  = (state == RDATA);
  assign mem_we        = (state == WRITE) && wen_q && !awerr_q;
  assign dbg_state     = state;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign aw_have = aw_q || aw_hs;
  assign w_have  = w_q || w_hs;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (aw_have && w_have) state_d = WRITE;
        else if (ar_hs)        state_d = READ;
      end
      WRITE:   state_d = WRESP;
      WRESP:   if (s_axi_bready) state_d = IDLE;
      READ:    state_d = RDATA;
      RDATA:   if (s_axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rdy_en      <= 1'b0;
      aw_q        <= 1'b0;
      w_q         <= 1'b0;
      awidx_q     <= '0;
      wbyte_q     <= '0;
      awerr_q     <= 1'b0;
      wen_q       <= 1'b0;
      rd_err_q    <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      s_axi_bresp <= '0;
      s_axi_rresp <= '0;
      s_axi_rdata <= '0;
    end else begin
      state  <= state_d;
      rdy_en <= 1'b1;
      if (aw_hs) begin
        awidx_q <= s_axi_awaddr[9:2];
        awerr_q <= aw_err;
      end
      if (w_hs) begin
        wbyte_q <= s_axi_wdata[7:0];
        wen_q   <= s_axi_wstrb[0];
      end
      // Bypass the latches when the completing beat arrives on this very edge.
      if (state == IDLE && state_d == WRITE) begin
        aw_q     <= 1'b0;
        w_q      <= 1'b0;
        mem_addr <= aw_q ? awidx_q : s_axi_awaddr[9:2];
        mem_din  <= w_q ? wbyte_q : s_axi_wdata[7:0];
      end else begin
        if (aw_hs) aw_q <= 1'b1;
        if (w_hs)  w_q  <= 1'b1;
      end
      if (ar_hs) begin
        mem_addr <= s_axi_araddr[9:2];
        rd_err_q <= ar_err;
      end
      if (state == WRITE) s_axi_bresp <= awerr_q ? 2'b10 : 2'b00;
      if (state == READ) begin
        s_axi_rdata <= rd_err_q ? 32'h0 : {24'h0, mem_dout};
        s_axi_rresp <= rd_err_q ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_axil_bram_ctrl.sv
// Randomized scoreboard bench for axil_bram_ctrl with a negedge 256x8 memory model.
module tb_axil_bram_ctrl;
  localparam int ADDR_W = 32;
`ifdef AXIL_BRAM_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid, s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid, s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid, s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;
  logic              mem_we;
  logic [7:0]        mem_addr, mem_din;
  logic [7:0]        mem_dout = 8'h0;
  logic [2:0]        dbg_state;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [15:0] exp_we_q[$];
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int b_hold_until = 0;
  int r_hold_until = 0;

  axil_bram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  // clock / cycle count
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cycle <= cycle + 1;

  // random back-pressure on B and R, with forced-low windows
  always @(posedge clk) begin
    #1;
    s_axi_bready = (cycle < b_hold_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
    s_axi_rready = (cycle < r_hold_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  function automatic logic [7:0] init_byte(int i);
    return (i == 2) ? 8'hB2 : 8'((i * 29 + 7) % 256);
  endfunction

  // memory model: port sampled on negedge
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (mem_we) mem[mem_addr] = mem_din;
      mem_dout = mem[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // reference model: word address selects a byte, upper bits alias unless SLVERR is enabled
  function automatic bit is_err(logic [31:0] a);
    return SLVERR_EN && (a >= 32'h400);
  endfunction
  function automatic int idx(logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (is_err(a)) exp_b_q.push_back(2'b10);
    else begin
      exp_b_q.push_back(2'b00);
      if (s[0]) begin
        exp_we_q.push_back({8'(idx(a)), d[7:0]});
        ref_mem[idx(a)] = d[7:0];
      end
    end
  endtask

  task automatic push_read(input logic [31:0] a);
    if (is_err(a)) exp_r_q.push_back({2'b10, 32'h0});
    else exp_r_q.push_back({2'b00, 24'h0, ref_mem[idx(a)]});
  endtask

  // monitor: pops expectations whenever the DUT presents a response or a memory write
  task automatic monitor();
    logic b_pend, r_pend;
    logic [1:0] b_last;
    logic [33:0] r_last, r_exp;
    logic [15:0] we_exp;
    logic [1:0] b_exp;
    b_pend = 1'b0; r_pend = 1'b0; b_last = '0; r_last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_pend = 1'b0;
        r_pend = 1'b0;
      end else begin
        if (mem_we) begin
          check("we_expected", exp_we_q.size(), 1 + exp_we_q.size() - (exp_we_q.size() > 0 ? 1 : 0));
          if (exp_we_q.size() > 0) begin
            we_exp = exp_we_q.pop_front();
            check("we_addr_din", {mem_addr, mem_din}, we_exp);
          end
        end
        if (b_pend) begin
          check("b_held", s_axi_bvalid, 1'b1);
          if (s_axi_bvalid) check("b_stable", s_axi_bresp, b_last);
        end
        if (s_axi_bvalid && s_axi_bready) begin
          check("b_expected", exp_b_q.size() > 0, 1'b1);
          if (exp_b_q.size() > 0) begin
            b_exp = exp_b_q.pop_front();
            check("bresp", s_axi_bresp, b_exp);
          end
        end
        b_pend = s_axi_bvalid && !s_axi_bready;
        b_last = s_axi_bresp;
        if (r_pend) begin
          check("r_held", s_axi_rvalid, 1'b1);
          if (s_axi_rvalid) check("r_stable", {s_axi_rresp, s_axi_rdata}, r_last);
        end
        if (s_axi_rvalid && s_axi_rready) begin
          check("r_expected", exp_r_q.size() > 0, 1'b1);
          if (exp_r_q.size() > 0) begin
            r_exp = exp_r_q.pop_front();
            check("rresp_rdata", {s_axi_rresp, s_axi_rdata}, r_exp);
          end
        end
        r_pend = s_axi_rvalid && !s_axi_rready;
        r_last = {s_axi_rresp, s_axi_rdata};
      end
    end
  endtask

  // driver tasks
  task automatic send_aw(input logic [31:0] a, input int dly);
    int n;
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1; s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 100);
    if (!s_axi_awready) check("aw_accept", s_axi_awready, 1'b1);
    @(posedge clk); #1; s_axi_awvalid = 1'b0; s_axi_awaddr = $urandom;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_wready && n < 100);
    if (!s_axi_wready) check("w_accept", s_axi_wready, 1'b1);
    @(posedge clk); #1; s_axi_wvalid = 1'b0; s_axi_wdata = $urandom;
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly);
    int n;
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1; s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 100);
    if (!s_axi_arready) check("ar_accept", s_axi_arready, 1'b1);
    @(posedge clk); #1; s_axi_arvalid = 1'b0; s_axi_araddr = $urandom;
    @(negedge clk); check("rd_lat_n1", s_axi_rvalid, 1'b0);
    @(negedge clk); check("rd_lat_n2", s_axi_rvalid, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("resp_timeout", exp_b_q.size() + exp_r_q.size(), 0);
    check("we_done", exp_we_q.size(), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead);
    push_write(a, d, s);
    fork
      send_w(d, s, (lead > 0) ? 0 : -lead);
      send_aw(a, (lead > 0) ? lead : 0);
    join
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] a);
    push_read(a);
    send_ar(a, 0);
    wait_done();
  endtask

  // asserts reset now, checks cleared outputs, releases, checks ready timing
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                       s_axi_rvalid, mem_we}, 6'b0);
    check("rst_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata, mem_addr, mem_din}, 52'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1; check("rdy_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    @(posedge clk); #1;
    check("rdy_up", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
  endtask

  initial begin
    logic [31:0] a, d;
    int lead;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    rst_n = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    fork monitor(); join_none
    #3;
    reset_pulse();

    // read of preloaded index 2
    do_read(32'h0000_0008);

    // W two cycles ahead of AW; ar must stay blocked while only W is latched
    push_write(32'h40, 32'h1234_56A5, 4'h1);
    fork
      send_w(32'h1234_56A5, 4'h1, 0);
      send_aw(32'h40, 2);
      begin
        @(posedge clk); #1;
        @(negedge clk); @(negedge clk);
        check("ar_blocked_partial", s_axi_arready, 1'b0);
      end
    join
    wait_done();
    do_read(32'h40);

    // strobe bit 0 low: no memory write
    do_write(32'h4, 32'h55, 4'he, 0);
    do_read(32'h4);

    // AR, AW, W together: write wins, bready held low for 3 response cycles
    b_hold_until = cycle + 6;
    push_write(32'h80, 32'h0000_007E, 4'h1);
    push_read(32'h80);
    fork
      send_aw(32'h80, 0);
      send_w(32'h0000_007E, 4'h1, 0);
      send_ar(32'h80, 0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        check("ar_blocked", s_axi_arready, 1'b0);
      end
    join
    wait_done();

    // address above 0x3FF: SLVERR or alias to index 0
    do_write(32'h400, 32'h3C, 4'h1, 0);
    do_read(32'h400);
    do_read(32'h0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        lead = $urandom_range(0, 6) - 3;
        do_write(a, d, 4'($urandom_range(0, 15)), lead);
      end else begin
        do_read(a);
      end
    end

    // reset during WRITE: the write is dropped
    @(posedge clk); #1;
    s_axi_awaddr = 32'h0000_0100; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_00E7; s_axi_wstrb = 4'hf; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("we_in_write", mem_we, 1'b1);
    reset_pulse();
    do_read(32'h0000_0100);

    // reset during RDATA: the response is dropped
    r_hold_until = cycle + 20;
    @(posedge clk); #1;
    s_axi_araddr = 32'h0000_0008; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(posedge clk); #1;
    check("rvalid_in_rdata", s_axi_rvalid, 1'b1);
    reset_pulse();
    r_hold_until = 0;
    do_read(32'h0000_0008);

    repeat (5) @(posedge clk);
    check("queues_empty", exp_b_q.size() + exp_r_q.size() + exp_we_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
